// File: rtl/dmem_lane_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_lane_ctrl_if
// Request/response bundle between the execute/memory stage and the data
// memory lane controller.
//   master : drives req, mem_we, io_we, size, uns, addr, wdata
//            samples ready, rvalid, rdata, misalign
//   slave  : the data memory (dmem_lane_ctrl)
// size encoding: 00 byte, 01 half, 10 word, 11 treated as word.
// ---------------------------------------------------------------------------
interface dmem_lane_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req;
  logic              mem_we;
  logic              io_we;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              misalign;

  modport master (
    output req, mem_we, io_we, size, uns, addr, wdata,
    input  ready, rvalid, rdata, misalign
  );

  modport slave (
    input  req, mem_we, io_we, size, uns, addr, wdata,
    output ready, rvalid, rdata, misalign
  );
endinterface

// File: rtl/dmem_lane_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_lane_ctrl
// Byte-lane data memory with byte/half/word stores, signed/unsigned sub-word
// loads (one-cycle registered read), a post-reset clear sequencer and a
// misalignment check.  Memory and IO stores share the same array.
//
// Ports:
//   clk    : system clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : dmem_lane_ctrl_if.slave (req/mem_we/io_we/size/uns/addr/wdata in,
//            ready/rvalid/rdata/misalign out)
//
// Build option:
//   DMEM_MISALIGN_TRAP_EN defined   : misaligned requests are dropped and
//                                     flagged on misalign one cycle later.
//   DMEM_MISALIGN_TRAP_EN undefined : misalign tied 0, offending low address
//                                     bits forced to 0 and the access proceeds.
// ---------------------------------------------------------------------------
module dmem_lane_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_lane_ctrl_if.slave   bus
);

  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam int IDX_W = ADDR_W - LB;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_clr_cnt;
  logic              r_ready;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_misalign;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_acc;
  logic              w_wr;
  logic              w_do;
  logic [LB-1:0]     w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [LANES-1:0]  w_be;
  logic [DATA_W-1:0] w_wrep;
  logic [DATA_W-1:0] w_rword;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_ext;

  assign w_acc   = r_ready & bus.req;
  assign w_wr    = bus.mem_we | bus.io_we;
  assign w_idx   = bus.addr[ADDR_W-1:LB];
  assign w_rword = r_mem[w_idx];
  // Lane offset after natural alignment; the selected field lands at bit 0.
  assign w_shift = w_rword >> {w_off, 3'b000};

`ifdef DMEM_MISALIGN_TRAP_EN
  logic w_mis;

  // Misalignment detect: half on an odd byte, word off a word boundary.
  always_comb begin
    w_mis = 1'b0;
    case (bus.size)
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = bus.addr[0];
      default: w_mis = (bus.addr[LB-1:0] != LB'(0));
    endcase
  end

  assign w_do = w_acc & ~w_mis;
`else
  assign w_do = w_acc;
`endif

  // Aligned lane offset: byte keeps its offset, half drops bit 0, word uses lane 0.
  always_comb begin
    w_off = LB'(0);
    case (bus.size)
      2'b00:   w_off = bus.addr[LB-1:0];
      2'b01:   w_off = bus.addr[LB-1:0] & ~LB'(1);
      default: w_off = LB'(0);
    endcase
  end

  // Byte-enable generation and store data replication across lanes.
  always_comb begin
    w_be   = '0;
    w_wrep = '0;
    for (int i = 0; i < LANES; i++) begin
      case (bus.size)
        2'b00: begin
          w_be[i]         = (LB'(i) == w_off);
          w_wrep[8*i +: 8] = bus.wdata[7:0];
        end
        2'b01: begin
          w_be[i]         = ((LB'(i) & ~LB'(1)) == w_off);
          w_wrep[8*i +: 8] = bus.wdata[8*(i%2) +: 8];
        end
        default: begin
          w_be[i]         = 1'b1;
          w_wrep[8*i +: 8] = bus.wdata[8*i +: 8];
        end
      endcase
    end
  end

  // Load extension of the selected field per size and uns.
  always_comb begin
    w_ext = '0;
    case (bus.size)
      2'b00: begin
        if (bus.uns) begin
          w_ext = {{(DATA_W-8){1'b0}}, w_shift[7:0]};
        end else begin
          w_ext = {{(DATA_W-8){w_shift[7]}}, w_shift[7:0]};
        end
      end
      2'b01: begin
        if (bus.uns) begin
          w_ext = {{(DATA_W-16){1'b0}}, w_shift[15:0]};
        end else begin
          w_ext = {{(DATA_W-16){w_shift[15]}}, w_shift[15:0]};
        end
      end
      default: w_ext = w_rword;
    endcase
  end

  // Control FSM: clear sequencing, ready, and registered load/misalign outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
      r_clr_cnt  <= '0;
      r_ready    <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_rvalid   <= 1'b0;
          r_misalign <= 1'b0;
          if (r_clr_cnt == LAST_IDX) begin
            r_state   <= ST_RUN;
            r_ready   <= 1'b1;
            r_clr_cnt <= '0;
          end else begin
            r_ready   <= 1'b0;
            r_clr_cnt <= r_clr_cnt + IDX_W'(1);
          end
        end
        ST_RUN: begin
          r_ready  <= 1'b1;
          r_rvalid <= w_do & ~w_wr;
          if (w_do && !w_wr) begin
            r_rdata <= w_ext;
          end
`ifdef DMEM_MISALIGN_TRAP_EN
          r_misalign <= w_acc & w_mis;
`else
          r_misalign <= 1'b0;
`endif
        end
        default: begin
          r_state    <= ST_CLEAR;
          r_clr_cnt  <= '0;
          r_ready    <= 1'b0;
          r_rvalid   <= 1'b0;
          r_misalign <= 1'b0;
        end
      endcase
    end
  end

  // Array write port: zero fill while clearing, otherwise lane-masked stores.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_do && w_wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
        end
      end
    end
  end

  assign bus.ready    = r_ready;
  assign bus.rvalid   = r_rvalid;
  assign bus.rdata    = r_rdata;
  assign bus.misalign = r_misalign;

endmodule
